// File: rtl/risc_v_mem_wb.sv
// MEM and WB back end of the five-stage RISC-V pipeline: EX/MEM register, byte-lane data
// memory, load formatting, MEM/WB register and the register-file write port.
module risc_v_mem_wb #(
  parameter int unsigned DMEM_AW = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemWrite_EX,
  input  logic [31:0] ALU_OUT_EX,
  input  logic [31:0] REG_DATA2_EX,
  input  logic [4:0]  RD_EX,
  input  logic [2:0]  FUNCT3_EX,
  output logic        RegWrite_MEM,
  output logic [31:0] ALU_OUT_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned DEPTH = 1 << DMEM_AW;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // EX/MEM pipeline register
  logic            regwrite_mem_q;
  logic            memtoreg_q;
  logic            memwrite_q;
  logic [XLEN-1:0] alu_mem_q;
  logic [XLEN-1:0] store_src_q;
  logic [RW-1:0]   rd_mem_q;
  logic [2:0]      funct3_q;

  // MEM/WB pipeline register
  logic            regwrite_wb_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] wb_data_d;
  logic [RW-1:0]   rd_wb_q;

  logic [XLEN-1:0] dmem [DEPTH];
  logic [DMEM_AW-1:0] word_idx;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] byte_shift;
  logic [XLEN-1:0] half_shift;
  logic [XLEN-1:0] load_data;
  logic [LANES-1:0] byte_en;
  logic [XLEN-1:0] store_data;

  // x0 writes are squashed on entry so both RegWrite outputs stay qualified
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_mem_q <= 1'b0;
      memtoreg_q     <= 1'b0;
      memwrite_q     <= 1'b0;
      alu_mem_q      <= '0;
      store_src_q    <= '0;
      rd_mem_q       <= '0;
      funct3_q       <= '0;
    end else begin
      regwrite_mem_q <= RegWrite_EX && (RD_EX != RW'(0));
      memtoreg_q     <= MemtoReg_EX;
      memwrite_q     <= MemWrite_EX;
      alu_mem_q      <= ALU_OUT_EX;
      store_src_q    <= REG_DATA2_EX;
      rd_mem_q       <= RD_EX;
      funct3_q       <= FUNCT3_EX;
    end
  end

  assign word_idx   = alu_mem_q[DMEM_AW+1:2];
  assign rd_word    = dmem[word_idx];
  assign byte_shift = rd_word >> {alu_mem_q[1:0], 3'b000};
  assign half_shift = rd_word >> {alu_mem_q[1], 4'b0000};

  // Load formatting; unknown sizes fall back to the full word
  always_comb begin
    load_data = rd_word;
    unique case (funct3_q)
      F3_B:    load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_H:    load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_BU:   load_data = {24'h000000, byte_shift[7:0]};
      F3_HU:   load_data = {16'h0000, half_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store lane enables and lane-replicated data
  always_comb begin
    byte_en    = '0;
    store_data = store_src_q;
    if (memwrite_q) begin
      unique case (funct3_q)
        F3_B: begin
          byte_en    = LANES'(4'b0001 << alu_mem_q[1:0]);
          store_data = {4{store_src_q[7:0]}};
        end
        F3_H: begin
          byte_en    = alu_mem_q[1] ? 4'b1100 : 4'b0011;
          store_data = {2{store_src_q[15:0]}};
        end
        F3_W:    byte_en = 4'b1111;
        default: byte_en = '0;
      endcase
    end
  end

  // memwrite_q is held clear asynchronously, so no store commits while reset is low
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (byte_en[i]) dmem[word_idx][8*i +: 8] <= store_data[8*i +: 8];
    end
  end

  assign wb_data_d = memtoreg_q ? load_data : alu_mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regwrite_wb_q <= 1'b0;
      wb_data_q     <= '0;
      rd_wb_q       <= '0;
    end else begin
      regwrite_wb_q <= regwrite_mem_q;
      wb_data_q     <= wb_data_d;
      rd_wb_q       <= rd_mem_q;
    end
  end

  assign RegWrite_MEM = regwrite_mem_q;
  assign ALU_OUT_MEM  = alu_mem_q;
  assign RD_MEM       = rd_mem_q;
  assign RegWrite_WB  = regwrite_wb_q;
  assign ALU_DATA_WB  = wb_data_q;
  assign RD_WB        = rd_wb_q;

endmodule

// File: tb/tb_risc_v_mem_wb.sv
// Bench for risc_v_mem_wb: directed vector table, reset sequences and random ops
// checked against a byte-array memory model with a two-slot pipeline tracker.
module tb_risc_v_mem_wb;

  localparam int unsigned AW    = 8;
  localparam int unsigned BYTES = 4 * (1 << AW);

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } op_t;

  typedef struct {
    op_t         op;
    bit          chk;
    logic [31:0] exp_data;
    bit          exp_rw;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite_EX, MemtoReg_EX, MemWrite_EX;
  logic [31:0] ALU_OUT_EX, REG_DATA2_EX;
  logic [4:0]  RD_EX;
  logic [2:0]  FUNCT3_EX;
  logic        RegWrite_MEM, RegWrite_WB;
  logic [31:0] ALU_OUT_MEM, ALU_DATA_WB;
  logic [4:0]  RD_MEM, RD_WB;

  int total = 0;
  int bad   = 0;

  logic [7:0] mb [BYTES];
  op_t         m_op;
  bit          m_chk, w_chk, m_erw, w_erw;
  logic [31:0] m_exp, w_exp;
  logic        w_rw;
  logic [31:0] w_data;
  logic [4:0]  w_rd;

  risc_v_mem_wb #(.DMEM_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemWrite_EX(MemWrite_EX),
    .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX(REG_DATA2_EX), .RD_EX(RD_EX), .FUNCT3_EX(FUNCT3_EX),
    .RegWrite_MEM(RegWrite_MEM), .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM),
    .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic op_t mk(input logic rw, input logic mtr, input logic mw, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rd, input logic [2:0] f3);
    op_t o;
    o.rw = rw; o.mtr = mtr; o.mw = mw; o.addr = addr; o.data = data; o.rd = rd; o.f3 = f3;
    return o;
  endfunction

  // Memory model: flat byte array, addresses taken modulo its size
  function automatic logic [31:0] mload(input logic [31:0] a, input logic [2:0] f3);
    int unsigned b  = a % BYTES;
    int unsigned hb = b - (b % 2);
    int unsigned wb = b - (b % 4);
    logic [31:0] w  = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
    logic [15:0] h  = {mb[hb+1], mb[hb]};
    logic [7:0]  by = mb[b];
    case (f3)
      3'b000:  return {{24{by[7]}}, by};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, by};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int unsigned b  = a % BYTES;
    int unsigned hb = b - (b % 2);
    int unsigned wb = b - (b % 4);
    case (f3)
      3'b000: mb[b] = d[7:0];
      3'b001: begin mb[hb] = d[7:0]; mb[hb+1] = d[15:8]; end
      3'b010: begin
        mb[wb] = d[7:0]; mb[wb+1] = d[15:8]; mb[wb+2] = d[23:16]; mb[wb+3] = d[31:24];
      end
      default: ;
    endcase
  endtask

  task automatic model_clear();
    m_op = '0; m_chk = 0; m_exp = '0; m_erw = 0;
    w_rw = 0; w_data = '0; w_rd = '0; w_chk = 0; w_exp = '0; w_erw = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rw_mem"}, 32'(RegWrite_MEM), 32'd0);
    check({tag, "_alu_mem"}, ALU_OUT_MEM, 32'd0);
    check({tag, "_rd_mem"}, 32'(RD_MEM), 32'd0);
    check({tag, "_rw_wb"}, 32'(RegWrite_WB), 32'd0);
    check({tag, "_data_wb"}, ALU_DATA_WB, 32'd0);
    check({tag, "_rd_wb"}, 32'(RD_WB), 32'd0);
  endtask

  // Called at a falling edge: drive one op, clock it, advance the model, compare both stages
  task automatic step(input op_t op, input bit c, input logic [31:0] e, input bit erw);
    RegWrite_EX = op.rw; MemtoReg_EX = op.mtr; MemWrite_EX = op.mw;
    ALU_OUT_EX = op.addr; REG_DATA2_EX = op.data; RD_EX = op.rd; FUNCT3_EX = op.f3;
    @(posedge clk);
    if (reset) begin
      w_rw   = m_op.rw && (m_op.rd != 5'd0);
      w_rd   = m_op.rd;
      w_data = m_op.mtr ? mload(m_op.addr, m_op.f3) : m_op.addr;
      w_chk  = m_chk; w_exp = m_exp; w_erw = m_erw;
      if (m_op.mw) mstore(m_op.addr, m_op.data, m_op.f3);
      m_op = op; m_chk = c; m_exp = e; m_erw = erw;
    end else begin
      model_clear();
    end
    #1;
    check("rw_mem", 32'(RegWrite_MEM), 32'(m_op.rw && (m_op.rd != 5'd0)));
    check("alu_mem", ALU_OUT_MEM, m_op.addr);
    check("rd_mem", 32'(RD_MEM), 32'(m_op.rd));
    check("rw_wb", 32'(RegWrite_WB), 32'(w_rw));
    check("data_wb", ALU_DATA_WB, w_data);
    check("rd_wb", 32'(RD_WB), 32'(w_rd));
    if (w_chk) begin
      check("vec_data_wb", ALU_DATA_WB, w_exp);
      check("vec_rw_wb", 32'(RegWrite_WB), 32'(w_erw));
    end
    @(negedge clk);
  endtask

  vec_t vecs[$];

  function automatic vec_t v(input op_t o, input bit c, input logic [31:0] e, input bit erw);
    vec_t r;
    r.op = o; r.chk = c; r.exp_data = e; r.exp_rw = erw;
    return r;
  endfunction

  initial begin
    op_t o;
    logic [31:0] a;
    model_clear();
    o = '0;
    RegWrite_EX = 0; MemtoReg_EX = 0; MemWrite_EX = 0;
    ALU_OUT_EX = '0; REG_DATA2_EX = '0; RD_EX = '0; FUNCT3_EX = '0;
    repeat (2) @(negedge clk);
    check_all_zero("por");
    reset = 1'b1;

    // Known contents everywhere so every random load is predictable
    for (int i = 0; i < (1 << AW); i++)
      step(mk(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0, 3'b010), 0, '0, 0);

    vecs.push_back(v(mk(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 3'b010), 0, 32'h0, 0));
    vecs.push_back(v(mk(1, 1, 0, 32'h10, 32'h0, 5'd1, 3'b010), 1, 32'hDEADBEEF, 1));
    vecs.push_back(v(mk(1, 1, 0, 32'h11, 32'h0, 5'd2, 3'b000), 1, 32'hFFFFFFBE, 1));
    vecs.push_back(v(mk(1, 1, 0, 32'h11, 32'h0, 5'd3, 3'b100), 1, 32'h000000BE, 1));
    vecs.push_back(v(mk(1, 1, 0, 32'h12, 32'h0, 5'd4, 3'b001), 1, 32'hFFFFDEAD, 1));
    vecs.push_back(v(mk(1, 1, 0, 32'h12, 32'h0, 5'd6, 3'b101), 1, 32'h0000DEAD, 1));
    vecs.push_back(v(mk(0, 0, 1, 32'h13, 32'h000000AA, 5'd0, 3'b000), 0, 32'h0, 0));
    vecs.push_back(v(mk(1, 1, 0, 32'h10, 32'h0, 5'd7, 3'b010), 1, 32'hAAADBEEF, 1));
    vecs.push_back(v(mk(0, 0, 1, 32'h10, 32'h00005555, 5'd0, 3'b001), 0, 32'h0, 0));
    vecs.push_back(v(mk(1, 1, 0, 32'h10, 32'h0, 5'd8, 3'b010), 1, 32'hAAAD5555, 1));
    vecs.push_back(v(mk(0, 0, 1, 32'h10, 32'hFFFFFFFF, 5'd0, 3'b011), 0, 32'h0, 0));
    vecs.push_back(v(mk(1, 1, 0, 32'h10, 32'h0, 5'd9, 3'b010), 1, 32'hAAAD5555, 1));
    vecs.push_back(v(mk(0, 0, 1, 32'h20, 32'h0BADF00D, 5'd0, 3'b010), 0, 32'h0, 0));
    vecs.push_back(v(mk(1, 1, 0, 32'h20, 32'h0, 5'd10, 3'b010), 1, 32'h0BADF00D, 1));
    vecs.push_back(v(mk(0, 0, 1, 32'h400, 32'h11111111, 5'd0, 3'b010), 0, 32'h0, 0));
    vecs.push_back(v(mk(1, 1, 0, 32'h0, 32'h0, 5'd11, 3'b010), 1, 32'h11111111, 1));
    vecs.push_back(v(mk(1, 1, 0, 32'h13, 32'h0, 5'd12, 3'b010), 1, 32'hAAAD5555, 1));
    vecs.push_back(v(mk(1, 0, 0, 32'h12345678, 32'h0, 5'd5, 3'b000), 1, 32'h12345678, 1));
    vecs.push_back(v(mk(1, 0, 0, 32'hCAFEF00D, 32'h0, 5'd0, 3'b000), 1, 32'hCAFEF00D, 0));
    vecs.push_back(v(mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'b000), 1, 32'h0, 0));
    vecs.push_back(v(mk(0, 0, 0, 32'h0, 32'h0, 5'd0, 3'b000), 0, 32'h0, 0));
    foreach (vecs[i]) step(vecs[i].op, vecs[i].chk, vecs[i].exp_data, vecs[i].exp_rw);

    // Reset mid-stream with a store sitting in MEM: it must never commit
    step(mk(1, 0, 0, 32'h55, 32'h0, 5'd3, 3'b000), 0, '0, 0);
    step(mk(0, 0, 1, 32'h40, 32'h77777777, 5'd0, 3'b010), 0, '0, 0);
    #2 reset = 1'b0;
    #1 check_all_zero("async_rst");
    model_clear();
    @(negedge clk);
    step(mk(0, 0, 1, 32'h44, 32'h66666666, 5'd0, 3'b010), 0, '0, 0);
    reset = 1'b1;
    step(mk(1, 1, 0, 32'h40, 32'h0, 5'd13, 3'b010), 0, '0, 0);
    step(mk(1, 1, 0, 32'h44, 32'h0, 5'd14, 3'b010), 0, '0, 0);
    step('0, 0, '0, 0);

    for (int i = 0; i < 400; i++) begin
      a = $urandom & 32'h0000_00FF;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      o = mk(1'($urandom), 1'($urandom), 1'($urandom), a, $urandom,
             5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
      step(o, 0, '0, 0);
    end
    step('0, 0, '0, 0);
    step('0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/risc_v_mem_wb.md
# risc_v_mem_wb

Back-end half of the five-stage RISC-V pipeline: it takes results leaving EX, performs the data-memory access, and drives the register-file write port of the IF/ID front end (`RegWrite_WB`, `ALU_DATA_WB`, `RD_WB`). It holds the EX/MEM and MEM/WB pipeline registers, a byte-addressable data memory and the write-back select mux. It also exports the MEM-stage destination and result for the forwarding unit.

## Interface
- `DMEM_AW`, default 8: word-address width; the data memory holds 2^DMEM_AW 32-bit words.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Clears both pipeline registers. Memory contents are not cleared.
- `RegWrite_EX` input 1: instruction in EX writes rd.
- `MemtoReg_EX` input 1: write-back source is load data (1) or ALU result (0).
- `MemWrite_EX` input 1: instruction in EX is a store.
- `ALU_OUT_EX` input 32: ALU result; this is the byte address for loads and stores.
- `REG_DATA2_EX` input 32: store data, already forwarded.
- `RD_EX` input 5: destination register.
- `FUNCT3_EX` input 3: load/store size and sign.
- `RegWrite_MEM` output 1: qualified RegWrite of the MEM stage, for forwarding.
- `ALU_OUT_MEM` output 32: ALU result in MEM.
- `RD_MEM` output 5: rd in MEM.
- `RegWrite_WB` output 1: register-file write enable, to ID.
- `ALU_DATA_WB` output 32: register-file write data, to ID.
- `RD_WB` output 5: register-file write address, to ID.

## Operation
- **EX/MEM register**
  - Captures all `*_EX` inputs every cycle.
  - There is no stall or flush input; the EX stage inserts bubbles by driving `RegWrite_EX=0` and `MemWrite_EX=0`.
- **Word index**
  - The memory word index is `ALU_OUT_MEM[DMEM_AW+1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo 4·2^DMEM_AW bytes.
- **Loads (combinational read in MEM)**
  - Byte lane is `addr[1:0]`; halfword lane is `addr[1]`. `addr[0]` is ignored for halfwords and `addr[1:0]` is ignored for words, so misaligned accesses are force-aligned and never trap.
  - `FUNCT3` 000 LB: sign-extended byte.
  - `FUNCT3` 001 LH: sign-extended halfword.
  - `FUNCT3` 010 LW: full word.
  - `FUNCT3` 100 LBU: zero-extended byte.
  - `FUNCT3` 101 LHU: zero-extended halfword.
  - Any other `FUNCT3` value returns the full word.
- **Stores (synchronous write at the rising edge ending the MEM cycle)**
  - Byte enables:
    - SB (000): one lane selected by `addr[1:0]`, data `REG_DATA2[7:0]` replicated.
    - SH (001): two lanes selected by `addr[1]`, data `REG_DATA2[15:0]`.
    - SW (010): all four lanes.
  - Any other `FUNCT3` value: no write.
  - Lanes that are not enabled keep their old contents.
- **MEM/WB register**
  - Captures qualified RegWrite, `RD`, and the write-back value. The write-back value is the formatted load data if MemtoReg=1, otherwise `ALU_OUT_MEM`.
  - Only that selected value is stored.
- **x0 protection**
  - `RegWrite_MEM` and `RegWrite_WB` are forced to 0 whenever their rd is 0.
  - `RD` and data still pass through unchanged.
- **Simultaneous store and load**
  - A store in MEM and a load in EX to the same word: the store commits at the edge, and the load reads the new data in the following cycle.
  - No bypass is needed because the read is combinational.
- `MemWrite=1` together with `RegWrite=1` is legal: both actions occur.

## Timing
- **Latency**
  - EX inputs sampled at edge n appear on the `*_MEM` outputs after edge n.
  - The same instruction appears on the `*_WB` outputs after edge n+1.
  - Throughput is one instruction per cycle.
- **Register-file handoff:** the `*_WB` outputs are held for exactly one cycle per instruction. The register file in ID writes at the next edge.
- **Reset**
  - While `reset=0`, all outputs are 0 immediately (asynchronous), independent of `clk`, and stores are suppressed.
  - After release, the first edge loads EX/MEM normally.
  - Reset asserted mid-store: that write does not occur if `reset=0` at the edge.
- Memory power-up contents are undefined. The bench initialises memory through stores.

## Test plan
- **Reset:** stream valid ops, drive `reset=0` between edges → all six outputs read 0 in the same cycle. After release, the next op reaches WB exactly 2 edges after it is sampled.
- **ALU pass-through:** `RegWrite_EX=1`, `MemtoReg_EX=0`, `ALU_OUT_EX=0x12345678`, `RD_EX=5` at edge n.
  - `RD_MEM=5` and `ALU_OUT_MEM=0x12345678` after edge n.
  - `RegWrite_WB=1`, `ALU_DATA_WB=0x12345678`, `RD_WB=5` after edge n+1, held for one cycle.
- **Load formatting:** SW 0xDEADBEEF to address 0x10, then read it back:
  - LW 0x10 → 0xDEADBEEF
  - LB 0x11 → 0xFFFFFFBE
  - LBU 0x11 → 0x000000BE
  - LH 0x12 → 0xFFFFDEAD
  - LHU 0x12 → 0x0000DEAD
- **Partial stores:** after the SW above:
  - SB data 0x000000AA to 0x13, then LW 0x10 → 0xAAADBEEF.
  - SH data 0x00005555 to 0x10, then LW 0x10 → 0xAAAD5555.
  - SW with FUNCT3=011 changes nothing.
- **Back-to-back store→load:** SW 0x0BADF00D to 0x20 in cycle k, LW 0x20 in cycle k+1 → `ALU_DATA_WB=0x0BADF00D`.
- **Boundaries:**
  - `RegWrite_EX=1` with `RD_EX=0` → `RegWrite_MEM=0` and `RegWrite_WB=0`.
  - With `DMEM_AW=8`, SW 0x11111111 to address 0x400, then LW 0x0 → 0x11111111 (wrap).
  - LW at 0x13 returns the word at 0x10 (misalignment ignored).
